// File: rtl/memtest_pkg.sv
// memtest_pkg
// Shared types for the memory checker. Holds the operation descriptor
// exchanged between the operation generator and the command executor,
// and the operation-type encodings.
package memtest_pkg;

    localparam int TX_WORD_ADDR_W = 8;   // word address bits carried per operation
    localparam int TX_COUNT_W     = 10;  // word_burst_count bits (count + 1 fits an 11-bit burstcount)
    localparam int TX_OFFSET_W    = 4;   // byte offset bits inside a 128-bit word

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    typedef struct packed {
        logic [TX_WORD_ADDR_W-1:0] word_address;
        logic                      high_burst_en;
        logic                      low_burst_en;
        logic [TX_COUNT_W-1:0]     word_burst_count;
        logic [TX_OFFSET_W-1:0]    start_offset;
        logic [TX_OFFSET_W-1:0]    end_offset;
    } transaction_type;

endpackage

// File: rtl/amm_cmd_executor_if.sv
// amm_cmd_executor_if
// Avalon-MM burst bus between the command executor (master) and the
// memory under test (slave).
//   address/write/read/writedata/byteenable/burstcount : master -> slave
//   waitrequest/readdatavalid/readdata                 : slave -> master
interface amm_cmd_executor_if #(
    parameter int AMM_DATA_W  = 128,
    parameter int AMM_ADDR_W  = 12,
    parameter int AMM_BURST_W = 11
);
    logic [AMM_ADDR_W-1:0]     address;
    logic                      write;
    logic                      read;
    logic [AMM_DATA_W-1:0]     writedata;
    logic [AMM_DATA_W/8-1:0]   byteenable;
    logic [AMM_BURST_W-1:0]    burstcount;
    logic                      waitrequest;
    logic                      readdatavalid;
    logic [AMM_DATA_W-1:0]     readdata;

    modport master (
        output address, write, read, writedata, byteenable, burstcount,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  address, write, read, writedata, byteenable, burstcount,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/byte_mask_gen.sv
// byte_mask_gen
// Purely combinational per-beat byte mask.
//   start_offset_i : lowest enabled byte on the first beat
//   end_offset_i   : highest enabled byte on the last beat
//   first_i/last_i : beat position; both set for a single-beat burst
//   mask_o         : BYTE_PER_WORD enable bits (all ones for middle beats)
module byte_mask_gen #(
    parameter int BYTE_PER_WORD = 16,
    parameter int BYTE_ADDR_W   = 4
) (
    input  logic [BYTE_ADDR_W-1:0]   start_offset_i,
    input  logic [BYTE_ADDR_W-1:0]   end_offset_i,
    input  logic                     first_i,
    input  logic                     last_i,
    output logic [BYTE_PER_WORD-1:0] mask_o
);

    // Each byte is enabled unless it lies below the start (first beat) or above the end (last beat).
    always_comb begin
        mask_o = {BYTE_PER_WORD{1'b0}};
        for (int i = 0; i < BYTE_PER_WORD; i++) begin
            mask_o[i] = (!first_i || (BYTE_ADDR_W'(i) >= start_offset_i)) &&
                        (!last_i  || (BYTE_ADDR_W'(i) <= end_offset_i));
        end
    end

endmodule

// File: rtl/amm_cmd_executor.sv
// amm_cmd_executor
// Accepts one operation per handshake and runs it as a single Avalon-MM
// burst: a write filled with data_pattern_i, or a read whose returned
// beats are forwarded with per-beat byte masks.
// Ports:
//   clk_i, rst_n_i                 : clock, asynchronous active-low reset
//   operation_valid_i/_type_i/_i   : operation offer (type 0 = write, 1 = read)
//   cmd_accept_ready_o             : high while idle
//   data_pattern_i                 : write fill byte
//   amm                            : Avalon-MM master bus
//   rd_data_valid_o/rd_data_o/rd_byteenable_o : registered read beats
//   rd_timeout_o                   : read watchdog pulse
// Optional feature macro AMM_EXEC_RD_TIMEOUT_EN: when defined, a read that
// sees no beat for RD_TIMEOUT cycles is abandoned with a one-cycle pulse.
module amm_cmd_executor
    import memtest_pkg::*;
#(
    parameter int AMM_DATA_W    = 128,
    parameter int AMM_ADDR_W    = 12,
    parameter int AMM_BURST_W   = 11,
    parameter int BYTE_PER_WORD = AMM_DATA_W / 8,
    parameter int BYTE_ADDR_W   = $clog2(BYTE_PER_WORD),
    parameter int ADDR_W        = AMM_ADDR_W - BYTE_ADDR_W,
    parameter int RD_TIMEOUT    = 1023
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     operation_valid_i,
    input  logic                     operation_type_i,
    input  transaction_type          operation_i,
    output logic                     cmd_accept_ready_o,
    input  logic [7:0]               data_pattern_i,
    amm_cmd_executor_if.master       amm,
    output logic                     rd_data_valid_o,
    output logic [AMM_DATA_W-1:0]    rd_data_o,
    output logic [BYTE_PER_WORD-1:0] rd_byteenable_o,
    output logic                     rd_timeout_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITE_BURST = 2'd1,
        READ_CMD    = 2'd2,
        READ_WAIT   = 2'd3
    } state_t;

    localparam logic [AMM_BURST_W-1:0] BEAT_ZERO = {AMM_BURST_W{1'b0}};
    localparam logic [AMM_BURST_W-1:0] BEAT_ONE  = AMM_BURST_W'(1'b1);
    localparam logic [AMM_BURST_W-1:0] BEAT_TWO  = AMM_BURST_W'(2'd2);

    state_t                   state_r, state_s;
    logic [AMM_BURST_W-1:0]   beats_r, beats_s;
    logic [AMM_BURST_W-1:0]   n_raw_s, n_acc_s;
    logic [BYTE_ADDR_W-1:0]   start_r, start_s, end_r, end_s;
    logic [BYTE_ADDR_W-1:0]   mask_start_s, mask_end_s;
    logic                     mask_first_s, mask_last_s;
    logic [BYTE_PER_WORD-1:0] mask_s;
    logic [AMM_ADDR_W-1:0]    address_r, address_s;
    logic                     write_r, write_s, read_r, read_s;
    logic [AMM_DATA_W-1:0]    wdata_r, wdata_s;
    logic [BYTE_PER_WORD-1:0] be_r, be_s;
    logic [AMM_BURST_W-1:0]   burstcount_r, burstcount_s;
    logic                     ready_r;
    logic                     rd_beat_s;
    logic                     rd_valid_r;
    logic [AMM_DATA_W-1:0]    rd_data_r;
    logic [BYTE_PER_WORD-1:0] rd_be_r;
    logic                     timeout_s, timeout_r;

    // Burst length of the offered operation; a computed length of zero still moves one word.
    always_comb begin
        if (operation_i.high_burst_en) begin
            n_raw_s = AMM_BURST_W'(operation_i.word_burst_count) + AMM_BURST_W'(operation_i.low_burst_en);
        end else begin
            n_raw_s = BEAT_ONE + AMM_BURST_W'(operation_i.low_burst_en);
        end
        n_acc_s = (n_raw_s == BEAT_ZERO) ? BEAT_ONE : n_raw_s;
    end

    // One mask generator is shared: it serves the first write beat at accept,
    // the next write beat during a burst, and the arriving read beat.
    always_comb begin
        mask_start_s = start_r;
        mask_end_s   = end_r;
        mask_first_s = 1'b0;
        mask_last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                mask_start_s = operation_i.start_offset[BYTE_ADDR_W-1:0];
                mask_end_s   = operation_i.end_offset[BYTE_ADDR_W-1:0];
                mask_first_s = 1'b1;
                mask_last_s  = (n_acc_s == BEAT_ONE);
            end
            WRITE_BURST: begin
                mask_first_s = 1'b0;
                mask_last_s  = (beats_r == BEAT_TWO);
            end
            READ_CMD, READ_WAIT: begin
                mask_first_s = (beats_r == burstcount_r);
                mask_last_s  = (beats_r == BEAT_ONE);
            end
            default: begin
                mask_first_s = 1'b0;
                mask_last_s  = 1'b0;
            end
        endcase
    end

    byte_mask_gen #(
        .BYTE_PER_WORD (BYTE_PER_WORD),
        .BYTE_ADDR_W   (BYTE_ADDR_W)
    ) u_byte_mask_gen (
        .start_offset_i (mask_start_s),
        .end_offset_i   (mask_end_s),
        .first_i        (mask_first_s),
        .last_i         (mask_last_s),
        .mask_o         (mask_s)
    );

    assign rd_beat_s = amm.readdatavalid && ((state_r == READ_CMD) || (state_r == READ_WAIT));

`ifdef AMM_EXEC_RD_TIMEOUT_EN
    localparam int WD_W = $clog2(RD_TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt_r;

    // Watchdog: cleared while the command is issued (so it starts at zero in READ_WAIT) and on every beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if ((state_r != READ_WAIT) || amm.readdatavalid) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (wd_cnt_r != WD_W'(RD_TIMEOUT)) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1'b1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    assign timeout_s = (state_r == READ_WAIT) && !amm.readdatavalid && (wd_cnt_r == WD_W'(RD_TIMEOUT));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output decode; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_s      = state_r;
        beats_s      = beats_r;
        start_s      = start_r;
        end_s        = end_r;
        address_s    = address_r;
        write_s      = write_r;
        read_s       = read_r;
        wdata_s      = wdata_r;
        be_s         = be_r;
        burstcount_s = burstcount_r;
        case (state_r)
            IDLE: begin
                if (operation_valid_i) begin
                    start_s      = operation_i.start_offset[BYTE_ADDR_W-1:0];
                    end_s        = operation_i.end_offset[BYTE_ADDR_W-1:0];
                    beats_s      = n_acc_s;
                    burstcount_s = n_acc_s;
                    address_s    = {operation_i.word_address[ADDR_W-1:0], {BYTE_ADDR_W{1'b0}}};
                    if (operation_type_i == OP_WRITE) begin
                        state_s = WRITE_BURST;
                        write_s = 1'b1;
                        wdata_s = {BYTE_PER_WORD{data_pattern_i}};
                        be_s    = mask_s;
                    end else begin
                        state_s = READ_CMD;
                        read_s  = 1'b1;
                        be_s    = {BYTE_PER_WORD{1'b1}};
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE_BURST: begin
                if (!amm.waitrequest) begin
                    if (beats_r == BEAT_ONE) begin
                        state_s = IDLE;
                        write_s = 1'b0;
                        beats_s = BEAT_ZERO;
                    end else begin
                        beats_s = beats_r - BEAT_ONE;
                        be_s    = mask_s;
                    end
                end else begin
                    beats_s = beats_r;
                end
            end
            READ_CMD: begin
                if (rd_beat_s) begin
                    beats_s = beats_r - BEAT_ONE;
                end else begin
                    beats_s = beats_r;
                end
                if (!amm.waitrequest) begin
                    read_s = 1'b0;
                    if (rd_beat_s && (beats_r == BEAT_ONE)) begin
                        state_s = IDLE;
                    end else begin
                        state_s = READ_WAIT;
                    end
                end else begin
                    state_s = READ_CMD;
                end
            end
            READ_WAIT: begin
                if (rd_beat_s) begin
                    beats_s = beats_r - BEAT_ONE;
                    if (beats_r == BEAT_ONE) begin
                        state_s = IDLE;
                    end else begin
                        state_s = READ_WAIT;
                    end
                end else if (timeout_s) begin
                    state_s = IDLE;
                    beats_s = BEAT_ZERO;
                end else begin
                    state_s = READ_WAIT;
                end
            end
            default: begin
                state_s = IDLE;
                write_s = 1'b0;
                read_s  = 1'b0;
            end
        endcase
    end

    // State, beat counter, latched offsets and the registered Avalon command outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= IDLE;
            beats_r      <= BEAT_ZERO;
            start_r      <= {BYTE_ADDR_W{1'b0}};
            end_r        <= {BYTE_ADDR_W{1'b0}};
            address_r    <= {AMM_ADDR_W{1'b0}};
            write_r      <= 1'b0;
            read_r       <= 1'b0;
            wdata_r      <= {AMM_DATA_W{1'b0}};
            be_r         <= {BYTE_PER_WORD{1'b0}};
            burstcount_r <= BEAT_ZERO;
            ready_r      <= 1'b1;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            beats_r      <= beats_s;
            start_r      <= start_s;
            end_r        <= end_s;
            address_r    <= address_s;
            write_r      <= write_s;
            read_r       <= read_s;
            wdata_r      <= wdata_s;
            be_r         <= be_s;
            burstcount_r <= burstcount_s;
            ready_r      <= (state_s == IDLE);
            timeout_r    <= timeout_s;
        end
    end

    // Registered copy of each accepted read beat and its mask; late beats after a timeout are not captured.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= {AMM_DATA_W{1'b0}};
            rd_be_r    <= {BYTE_PER_WORD{1'b0}};
        end else if (rd_beat_s) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= amm.readdata;
            rd_be_r    <= mask_s;
        end else begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= rd_data_r;
            rd_be_r    <= rd_be_r;
        end
    end

    assign cmd_accept_ready_o = ready_r;
    assign amm.address        = address_r;
    assign amm.write          = write_r;
    assign amm.read           = read_r;
    assign amm.writedata      = wdata_r;
    assign amm.byteenable     = be_r;
    assign amm.burstcount     = burstcount_r;
    assign rd_data_valid_o    = rd_valid_r;
    assign rd_data_o          = rd_data_r;
    assign rd_byteenable_o    = rd_be_r;
    assign rd_timeout_o       = timeout_r;

endmodule
